arbiter_rr_param: RTL and testbench

- Parametrised N-way request/grant arbiter; successor to the fixed ArbiterTOP.
- Supports round-robin or fixed-priority mode, selected at run time.
- Adds bounded grant tenure (preemption after MAX_HOLD cycles) and a registered one-hot grant with encoded owner ID.
- Sits between N bus masters and a shared resource. Driven from a parametrised if_to_arbiter-style interface in the test bench.

---
 rtl/arbiter_rr_param.sv | 212 +++++++++++++++++++++
 tb/tb_arbiter_rr_param.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/arbiter_rr_param.sv
// -----------------------------------------------------------------------------
// arbiter_rr_param
//
// N-way request/grant arbiter with run-time selectable round-robin or
// fixed-priority selection, bounded grant tenure (preemption after MAX_HOLD
// cycles while others wait), and a registered one-hot grant with encoded
// owner ID.
//
// Optional feature macro: ARB_STARVATION_MON_EN
//   defined   -> per-requester 8-bit wait counters drive the starve flags
//   undefined -> starve is tied to zero and no counters are built
// -----------------------------------------------------------------------------
module arbiter_rr_param #(
    parameter  int NUM_REQ      = 4,
    parameter  int MAX_HOLD     = 8,
    parameter  int STARVE_LIMIT = 32,
    localparam int IDW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int HCW          = $clog2(MAX_HOLD + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               mode,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid,
    output logic [IDW-1:0]     grant_id,
    output logic [HCW-1:0]     hold_cnt,
    output logic [NUM_REQ-1:0] starve
);

    // Elaboration-time guards on the legal parameter ranges.
    if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
        $error("arbiter_rr_param: NUM_REQ must be in 2..16");
    end
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("arbiter_rr_param: MAX_HOLD must be in 1..255");
    end
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_starve_limit
        $error("arbiter_rr_param: STARVE_LIMIT must be in 1..255");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_e;

    localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);
    localparam logic [IDW-1:0] PTR_RESET = IDW'(NUM_REQ - 1);

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic                 valid_q, valid_d;
    logic [IDW-1:0]       id_q, id_d;
    logic [HCW-1:0]       hold_q, hold_d;
    logic [IDW-1:0]       ptr_q, ptr_d;

    logic [NUM_REQ-1:0]   others;
    logic                 select;
    logic [IDW-1:0]       winner;

    // Pick a winner from the candidate vector. Fixed mode: lowest index.
    // Round-robin: first candidate above the pointer, else wrap to the lowest.
    // Loops run from high to low so the last hit is the highest priority.
    function automatic logic [IDW-1:0] pick_winner(
        input logic [NUM_REQ-1:0] cand,
        input logic               fixed_mode,
        input logic [IDW-1:0]     ptr
    );
        logic [IDW-1:0] lowest;
        logic [IDW-1:0] above;
        logic           found_above;
        lowest      = '0;
        above       = '0;
        found_above = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                lowest = IDW'(i);
                if (i > int'(ptr)) begin
                    above       = IDW'(i);
                    found_above = 1'b1;
                end
            end
        end
        if (fixed_mode || !found_above) begin
            return lowest;
        end
        return above;
    endfunction

    // Next-state logic: decide whether a selection event happens this edge
    // (new grant, handoff or preemption) and update hold counter otherwise.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; an unassigned path in always_comb infers a latch.
        state_d = state_q;
        grant_d = grant_q;
        id_d    = id_q;
        hold_d  = hold_q;
        ptr_d   = ptr_q;
        select  = 1'b0;

        // The current owner is never a candidate: this covers both handoff
        // (owner already released) and preemption (owner excluded).
        others  = req & ~grant_q;
        winner  = pick_winner(others, mode, ptr_q);

        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    select = 1'b1;
                end
            end
            OWNED: begin
                if (!(|(req & grant_q))) begin
                    if (|others) begin
                        select = 1'b1;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        id_d    = '0;
                        hold_d  = '0;
                    end
                end else if ((|others) && (hold_q == HOLD_LAST)) begin
                    select = 1'b1;
                end else if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (select) begin
            state_d = OWNED;
            grant_d = NUM_REQ'(1) << winner;
            id_d    = winner;
            hold_d  = '0;
            ptr_d   = winner;
        end

        valid_d = |grant_d;
    end

    // State, grant and pointer registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // the pre-edge values regardless of statement order.
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            valid_q <= 1'b0;
            id_q    <= '0;
            hold_q  <= '0;
            ptr_q   <= PTR_RESET;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            id_q    <= id_d;
            hold_q  <= hold_d;
            ptr_q   <= ptr_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = valid_q;
    assign grant_id    = id_q;
    assign hold_cnt    = hold_q;

`ifdef ARB_STARVATION_MON_EN
    logic [7:0]         wait_q [NUM_REQ];
    logic [7:0]         wait_d [NUM_REQ];
    logic [NUM_REQ-1:0] starve_q, starve_d;

    // Wait counters: count cycles a request is pending but not granted,
    // saturating at 255; starve flags follow the updated count.
    always_comb begin
        starve_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i] && !grant_q[i]) begin
                wait_d[i] = (wait_q[i] == 8'hFF) ? wait_q[i] : wait_q[i] + 8'd1;
            end else begin
                wait_d[i] = 8'd0;
            end
            starve_d[i] = (wait_d[i] >= 8'(STARVE_LIMIT));
        end
    end

    // Wait counter and starve flag registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: the counter array is reset explicitly because its
            // contents feed starve directly; it is state, not storage.
            for (int i = 0; i < NUM_REQ; i++) begin
                wait_q[i] <= 8'd0;
            end
            starve_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                wait_q[i] <= wait_d[i];
            end
            starve_q <= starve_d;
        end
    end

    assign starve = starve_q;
`else
    assign starve = '0;
`endif

endmodule

// File: tb/tb_arbiter_rr_param.sv
// -----------------------------------------------------------------------------
// tb_arbiter_rr_param
//
// Directed scenarios plus randomized traffic, checked every cycle against a
// behavioural model that tracks the owner as an integer and applies the
// arbitration rules directly. Starvation expectations follow
// ARB_STARVATION_MON_EN (zero when it is undefined).
// -----------------------------------------------------------------------------
module tb_arbiter_rr_param;

    localparam int NUM_REQ      = 4;
    localparam int MAX_HOLD     = 8;
    localparam int STARVE_LIMIT = 12;
    localparam int IDW          = 2;
    localparam int HCW          = 4;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic [NUM_REQ-1:0] req   = '0;
    logic               mode  = 1'b0;
    logic [NUM_REQ-1:0] grant;
    logic               grant_valid;
    logic [IDW-1:0]     grant_id;
    logic [HCW-1:0]     hold_cnt;
    logic [NUM_REQ-1:0] starve;

    arbiter_rr_param #(
        .NUM_REQ      (NUM_REQ),
        .MAX_HOLD     (MAX_HOLD),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .mode        (mode),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .hold_cnt    (hold_cnt),
        .starve      (starve)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int               m_owner;
    int               m_hold;
    int               m_ptr;
    int               m_wait [NUM_REQ];
    logic [NUM_REQ-1:0] m_starve;

    function automatic int pick(input logic [NUM_REQ-1:0] cand, input logic fixed_mode,
                                input int ptr);
        if (fixed_mode) begin
            for (int i = 0; i < NUM_REQ; i++) if (cand[i]) return i;
        end else begin
            for (int off = 1; off <= NUM_REQ; off++) begin
                int idx;
                idx = (ptr + off) % NUM_REQ;
                if (cand[idx]) return idx;
            end
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner  = -1;
        m_hold   = 0;
        m_ptr    = NUM_REQ - 1;
        m_starve = '0;
        for (int i = 0; i < NUM_REQ; i++) m_wait[i] = 0;
    endtask

    task automatic model_edge(input logic [NUM_REQ-1:0] r, input logic m);
        logic [NUM_REQ-1:0] others;
        bit                 sel;
        int                 w;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r[i] && m_owner != i) m_wait[i] = (m_wait[i] < 255) ? m_wait[i] + 1 : 255;
            else                      m_wait[i] = 0;
            m_starve[i] = (m_wait[i] >= STARVE_LIMIT);
        end
        others = r;
        if (m_owner >= 0) others[m_owner] = 1'b0;
        sel = 0;
        if (m_owner < 0) begin
            sel = (r != 0);
        end else if (!r[m_owner]) begin
            if (others != 0) sel = 1;
            else begin
                m_owner = -1;
                m_hold  = 0;
            end
        end else if (others != 0 && m_hold == MAX_HOLD - 1) begin
            sel = 1;
        end else if (m_hold < MAX_HOLD - 1) begin
            m_hold++;
        end
        if (sel) begin
            w       = pick(others, m, m_ptr);
            m_owner = w;
            m_ptr   = w;
            m_hold  = 0;
        end
    endtask

    task automatic check_all();
        logic [NUM_REQ-1:0] exp_grant;
        logic [NUM_REQ-1:0] exp_starve;
        exp_grant = (m_owner < 0) ? '0 : NUM_REQ'(1) << m_owner;
`ifdef ARB_STARVATION_MON_EN
        exp_starve = m_starve;
`else
        exp_starve = '0;
`endif
        check("grant",       32'(grant),       32'(exp_grant));
        check("grant_valid", 32'(grant_valid), 32'(m_owner >= 0));
        check("grant_id",    32'(grant_id),    (m_owner < 0) ? 0 : m_owner);
        check("hold_cnt",    32'(hold_cnt),    m_hold);
        check("starve",      32'(starve),      32'(exp_starve));
    endtask

    // One clock edge: inputs are stable since the previous step, outputs are
    // sampled 1 ns after the edge.
    task automatic step();
        logic [NUM_REQ-1:0] r;
        logic               m;
        r = req;
        m = mode;
        @(posedge clock);
        model_edge(r, m);
        #1;
        check_all();
    endtask

    // Reset asserted between edges; outputs must clear before any edge.
    task automatic async_reset();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("rst_grant", 32'(grant), 0);
        check("rst_id",    32'(grant_id), 0);
        check("rst_hold",  32'(hold_cnt), 0);
        check_all();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_all();
        reset = 1'b0;

        // Reset mid-grant, then first grant after release.
        req = 4'b0001;
        step();
        check("first_grant", 32'(grant), 32'h1);
        repeat (3) step();
        async_reset();
        req = 4'b0001;
        step();
        check("post_rst_grant", 32'(grant), 32'h1);

        // Round-robin rotation with one-cycle release by each owner.
        begin
            logic [NUM_REQ-1:0] rr_seq [5];
            rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
            async_reset();
            mode = 1'b0;
            req  = 4'b1111;
            for (int k = 0; k < 5; k++) begin
                step();
                check("rr_seq", 32'(grant), 32'(rr_seq[k]));
                req = 4'b1111 & ~rr_seq[k];
            end
        end

        // Preemption after MAX_HOLD cycles.
        async_reset();
        mode = 1'b0;
        req  = 4'b0001;
        step();
        repeat (3) step();
        check("pre_hold3", 32'(hold_cnt), 3);
        req = 4'b0101;
        repeat (4) begin
            step();
            check("pre_keep", 32'(grant), 32'h1);
        end
        check("pre_hold7", 32'(hold_cnt), 7);
        step();
        check("pre_grant", 32'(grant), 32'h4);
        check("pre_hold0", 32'(hold_cnt), 0);

        // Fixed priority: lower index waits for preemption.
        async_reset();
        mode = 1'b1;
        req  = 4'b1010;
        step();
        check("fix_first", 32'(grant), 32'h2);
        req = 4'b1011;
        repeat (7) begin
            step();
            check("fix_keep", 32'(grant), 32'h2);
        end
        step();
        check("fix_preempt", 32'(grant), 32'h1);

        // Lone holder: constant grant, saturating hold counter.
        async_reset();
        mode = 1'b0;
        req  = 4'b0100;
        repeat (20) begin
            step();
            check("lone_grant", 32'(grant), 32'h4);
        end
        check("lone_hold", 32'(hold_cnt), MAX_HOLD - 1);

        // Requester 3 starves behind 0 and 1 in fixed mode, then is served.
        async_reset();
        mode = 1'b1;
        req  = 4'b1011;
        repeat (30) step();
`ifdef ARB_STARVATION_MON_EN
        check("starve3_set", 32'(starve[3]), 1);
`endif
        req = 4'b1000;
        repeat (3) step();
        check("starve3_served", 32'(grant), 32'h8);

        // Randomized traffic with occasional mode flips and async resets.
        async_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if ($urandom_range(0, 5) == 0) req[i] = ~req[i];
            end
            if ($urandom_range(0, 63) == 0) mode = ~mode;
            if ($urandom_range(0, 499) == 0) async_reset();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
